// File: rtl/parking_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : parking_gate_ctrl
// Description : Entry-barrier and occupancy controller for the parking lot.
//               It counts the one-cycle car_in / car_out pulses from the
//               sensor FSM into a saturating occupancy count. It drives the
//               entry barrier motor through an open / hold / close sequence
//               and refuses entry while the lot is full.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CAPACITY      number of spaces (1 .. 2**CNT_W-1)
//   CNT_W         occupancy counter width
//   TRAVEL_CYCLES barrier motor travel time, opening or closing (>=1)
//   HOLD_CYCLES   longest time the barrier stays open waiting for a car (>=1)
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   entry_req  in   entry request button (level, synchronous)
//   car_in     in   one-cycle pulse: a car completed entry
//   car_out    in   one-cycle pulse: a car completed exit
//   obstacle   in   (PARK_GATE_OBSTACLE_EN only) something is under the barrier
//   gate_up    out  motor drive, raise barrier   (state OPENING)
//   gate_down  out  motor drive, lower barrier   (state CLOSING)
//   gate_open  out  barrier fully open           (state OPEN)
//   occupancy  out  cars currently inside
//   full       out  occupancy == CAPACITY
//   err        out  one-cycle pulse on an overflow or underflow attempt
//
// Build option
//   PARK_GATE_OBSTACLE_EN  adds the obstacle input. An obstacle while the
//                          barrier is closing reopens it, even when the lot
//                          is full. An obstacle while the barrier is open
//                          freezes the hold timeout.
// ============================================================================
module parking_gate_ctrl #(
    parameter int CAPACITY      = 16,
    parameter int CNT_W         = 5,
    parameter int TRAVEL_CYCLES = 8,
    parameter int HOLD_CYCLES   = 50
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             car_in,
    input  logic             car_out,
`ifdef PARK_GATE_OBSTACLE_EN
    input  logic             obstacle,
`endif
    output logic             gate_up,
    output logic             gate_down,
    output logic             gate_open,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             err
);

    // ------------------------------------------------------------------------
    // Timer sizing. One timer serves both the travel and the hold phases. It
    // must reach max(TRAVEL_CYCLES, HOLD_CYCLES)-1. The width is at least 1 bit
    // so that a 1-cycle configuration still has a legal vector.
    // ------------------------------------------------------------------------
    localparam int c_TMR_MAX = (TRAVEL_CYCLES > HOLD_CYCLES) ? TRAVEL_CYCLES
                                                             : HOLD_CYCLES;
    localparam int c_TMR_W   = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;

    localparam logic [c_TMR_W-1:0] c_TRAVEL_LAST = c_TMR_W'(TRAVEL_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_HOLD_LAST   = c_TMR_W'(HOLD_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE     = c_TMR_W'(1);
    localparam logic [CNT_W-1:0]   c_CAP         = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0]   c_CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'd0,
        ST_OPENING = 2'd1,
        ST_OPEN    = 2'd2,
        ST_CLOSING = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_TMR_W-1:0]   r_timer;
    logic                 w_timer_hold;

    logic [CNT_W-1:0]     r_occupancy;
    logic                 r_err;

    logic                 w_obstacle;
    logic                 w_inc;
    logic                 w_dec;
    logic                 w_at_cap;
    logic                 w_empty;
    logic                 w_admit;

`ifdef PARK_GATE_OBSTACLE_EN
    assign w_obstacle = obstacle;
`else
    assign w_obstacle = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Occupancy counter.
    // If car_in and car_out arrive together, they cancel. In that case no
    // boundary check is made and no err is raised, even at 0 or CAPACITY.
    // ------------------------------------------------------------------------
    assign w_inc    = car_in & ~car_out;
    assign w_dec    = car_out & ~car_in;
    assign w_at_cap = (r_occupancy == c_CAP);
    assign w_empty  = (r_occupancy == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_occupancy <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_inc && !w_at_cap) begin
                r_occupancy <= r_occupancy + c_CNT_ONE;
            end else if (w_dec && !w_empty) begin
                r_occupancy <= r_occupancy - c_CNT_ONE;
            end
            r_err <= (w_inc && w_at_cap) || (w_dec && w_empty);
        end
    end

    // full is decoded from the registered count. A request raised in the same
    // cycle as the car_in that fills the lot still sees the old value and is
    // admitted.
    assign full    = w_at_cap;
    assign w_admit = entry_req & ~w_at_cap;

    // ------------------------------------------------------------------------
    // Barrier sequencer: state register and timer.
    // The timer restarts on every state change. The only other case where it
    // does not advance is an obstacle freezing the hold phase.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_CLOSED;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_timer <= '0;
            end else if (!w_timer_hold) begin
                r_timer <= r_timer + c_TMR_ONE;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_hold = 1'b0;
        case (r_state)
            ST_CLOSED: begin
                // A request on a full lot is refused silently.
                if (w_admit) begin
                    w_state_nxt = ST_OPENING;
                end
            end
            ST_OPENING: begin
                if (r_timer == c_TRAVEL_LAST) begin
                    w_state_nxt = ST_OPEN;
                end
            end
            ST_OPEN: begin
                // entry_req is ignored here. The car passing through, or the
                // hold timeout, closes the barrier.
                if (car_in) begin
                    w_state_nxt = ST_CLOSING;
                end else if (w_obstacle) begin
                    w_timer_hold = 1'b1;
                end else if (r_timer == c_HOLD_LAST) begin
                    w_state_nxt = ST_CLOSING;
                end
            end
            ST_CLOSING: begin
                // A reversal takes priority over completing the close.
                // The motor then starts a full-length opening travel.
                if (w_admit || w_obstacle) begin
                    w_state_nxt = ST_OPENING;
                end else if (r_timer == c_TRAVEL_LAST) begin
                    w_state_nxt = ST_CLOSED;
                end
            end
            default: begin
                w_state_nxt = ST_CLOSED;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------------
    assign gate_up   = (r_state == ST_OPENING);
    assign gate_open = (r_state == ST_OPEN);
    assign gate_down = (r_state == ST_CLOSING);
    assign occupancy = r_occupancy;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_parking_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_parking_gate_ctrl
// Description : Self-checking bench for parking_gate_ctrl. It uses two
//               instances: one with default parameters and one with
//               CAPACITY=3. Both are compared every cycle against a
//               countdown-based behavioural model. A few directed scenarios
//               also check hand-computed literal values.
// Revision    : 1.0 - initial release
// Build option: PARK_GATE_OBSTACLE_EN (connects and exercises obstacle)
// ============================================================================
module tb_parking_gate_ctrl;

    localparam int TRAVEL = 8;
    localparam int HOLD   = 50;
`ifdef PARK_GATE_OBSTACLE_EN
    localparam bit OBS = 1'b1;
`else
    localparam bit OBS = 1'b0;
`endif

    // Model phases: 0 closed, 1 raising, 2 up, 3 lowering.
    typedef struct packed {
        int mode;
        int rem;   // cycles left in the current timed phase
        int occ;
        bit err;
    } mst_t;

    int   cap [2] = '{16, 3};
    mst_t m [2];

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic entry_req = 1'b0;
    logic car_in = 1'b0;
    logic car_out = 1'b0;
    logic obstacle = 1'b0;

    logic       g_up [2];
    logic       g_dn [2];
    logic       g_op [2];
    logic       fl   [2];
    logic       er   [2];
    logic [4:0] occ  [2];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    parking_gate_ctrl u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .entry_req (entry_req),
        .car_in    (car_in),
        .car_out   (car_out),
`ifdef PARK_GATE_OBSTACLE_EN
        .obstacle  (obstacle),
`endif
        .gate_up   (g_up[0]),
        .gate_down (g_dn[0]),
        .gate_open (g_op[0]),
        .occupancy (occ[0]),
        .full      (fl[0]),
        .err       (er[0])
    );

    parking_gate_ctrl #(.CAPACITY(3)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .entry_req (entry_req),
        .car_in    (car_in),
        .car_out   (car_out),
`ifdef PARK_GATE_OBSTACLE_EN
        .obstacle  (obstacle),
`endif
        .gate_up   (g_up[1]),
        .gate_down (g_dn[1]),
        .gate_open (g_op[1]),
        .occupancy (occ[1]),
        .full      (fl[1]),
        .err       (er[1])
    );

    // ------------------------------------------------------------------------
    // Behavioural model: one edge of the lot/barrier rules.
    // ------------------------------------------------------------------------
    function automatic mst_t model_next(input mst_t s, input int cp, input bit req,
                                        input bit ci, input bit co, input bit ob);
        mst_t n;
        bit   was_full;
        bit   want;
        n        = s;
        was_full = (s.occ == cp);
        want     = req && !was_full;
        // counter
        n.err = 1'b0;
        if (ci && !co) begin
            if (s.occ == cp) n.err = 1'b1;
            else             n.occ = s.occ + 1;
        end else if (co && !ci) begin
            if (s.occ == 0)  n.err = 1'b1;
            else             n.occ = s.occ - 1;
        end
        // barrier
        case (s.mode)
            0: if (want) begin n.mode = 1; n.rem = TRAVEL; end
            1: begin
                n.rem = s.rem - 1;
                if (n.rem == 0) begin n.mode = 2; n.rem = HOLD; end
            end
            2: begin
                if (ci) begin
                    n.mode = 3; n.rem = TRAVEL;
                end else if (!ob) begin
                    n.rem = s.rem - 1;
                    if (n.rem == 0) begin n.mode = 3; n.rem = TRAVEL; end
                end
            end
            default: begin
                if (want || ob) begin
                    n.mode = 1; n.rem = TRAVEL;
                end else begin
                    n.rem = s.rem - 1;
                    if (n.rem == 0) begin n.mode = 0; n.rem = 0; end
                end
            end
        endcase
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) m[k] <= '0;
            else       m[k] <= model_next(m[k], cap[k], entry_req, car_in, car_out,
                                          OBS && obstacle);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("d%0d.gate_up", k),   32'(g_up[k]), 32'(m[k].mode == 1));
                check($sformatf("d%0d.gate_open", k), 32'(g_op[k]), 32'(m[k].mode == 2));
                check($sformatf("d%0d.gate_down", k), 32'(g_dn[k]), 32'(m[k].mode == 3));
                check($sformatf("d%0d.occupancy", k), 32'(occ[k]),  32'(m[k].occ));
                check($sformatf("d%0d.full", k),      32'(fl[k]),   32'(m[k].occ == cap[k]));
                check($sformatf("d%0d.err", k),       32'(er[k]),   32'(m[k].err));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count consecutive cycles a barrier output stays high (0 up, 1 open, 2 down).
    task automatic run_len(input int k, input int which, output int n);
        n = 0;
        while (n < 200 && ((which == 0) ? g_up[k] : (which == 1) ? g_op[k] : g_dn[k])) begin
            n++;
            step();
        end
    endtask

    task automatic pulse_in();
        car_in = 1'b1; step(); car_in = 1'b0;
    endtask

    task automatic request();
        entry_req = 1'b1; step(); entry_req = 1'b0;
    endtask

    int n;

    initial begin
        // ---------------- reset ----------------
        repeat (3) step();
        chk_en = 1'b1;
        check("rst.gate_up",   32'(g_up[0]), 0);
        check("rst.gate_down", 32'(g_dn[0]), 0);
        check("rst.gate_open", 32'(g_op[0]), 0);
        check("rst.occupancy", 32'(occ[0]),  0);
        check("rst.full",      32'(fl[1]),   0);
        check("rst.err",       32'(er[0]),   0);
        reset = 1'b0;
        step();

        // ---------------- basic entry ----------------
        request();
        run_len(0, 0, n);
        check("basic.up_len", n, 8);
        check("basic.opened", 32'(g_op[0]), 1);
        step(); step();
        pulse_in();
        run_len(0, 2, n);
        check("basic.down_len", n, 8);
        check("basic.occ", 32'(occ[0]), 1);
        check("basic.closed", 32'(g_op[0] | g_up[0]), 0);

        // ---------------- timeout ----------------
        request();
        run_len(0, 0, n);
        check("tmo.up_len", n, 8);
        run_len(0, 1, n);
        check("tmo.open_len", n, 50);
        run_len(0, 2, n);
        check("tmo.down_len", n, 8);
        check("tmo.occ", 32'(occ[0]), 1);

        // ---------------- full lot (instance with CAPACITY=3) ----------------
        pulse_in(); step();
        pulse_in();
        check("full.occ", 32'(occ[1]), 3);
        check("full.flag", 32'(fl[1]), 1);
        pulse_in();
        check("full.ovf_occ", 32'(occ[1]), 3);
        check("full.ovf_err", 32'(er[1]), 1);
        step();
        check("full.err_1cyc", 32'(er[1]), 0);
        entry_req = 1'b1;
        step();
        check("full.refused", 32'(g_up[1]), 0);
        check("full.big_lot_opens", 32'(g_up[0]), 1);
        step();
        entry_req = 1'b0;
        check("full.still_refused", 32'(g_up[1]), 0);
        repeat (80) step();

        // ---------------- underflow / simultaneous ----------------
        reset = 1'b1; step(); reset = 1'b0; step();
        car_out = 1'b1; step(); car_out = 1'b0;
        check("unf.err", 32'(er[0]), 1);
        check("unf.occ", 32'(occ[0]), 0);
        step();
        pulse_in(); pulse_in();
        car_in = 1'b1; car_out = 1'b1; step(); car_in = 1'b0; car_out = 1'b0;
        check("sim.occ", 32'(occ[0]), 2);
        check("sim.err", 32'(er[0]), 0);

        // ---------------- reversal ----------------
        request();
        run_len(0, 0, n);
        step();
        pulse_in();
        check("rev.closing", 32'(g_dn[0]), 1);
        step(); step(); step();
        request();
        check("rev.up_again", 32'(g_up[0]), 1);
        run_len(0, 0, n);
        check("rev.up_len", n, 8);
        repeat (70) step();

        // ---------------- reset during OPENING ----------------
        request();
        step(); step();
        check("rstmid.opening", 32'(g_up[0]), 1);
        reset = 1'b1;
        #1;
        check("rstmid.up_low", 32'(g_up[0]), 0);
        check("rstmid.occ", 32'(occ[0]), 0);
        check("rstmid.occ1", 32'(occ[1]), 0);
        step();
        reset = 1'b0;
        step();

`ifdef PARK_GATE_OBSTACLE_EN
        // ---------------- obstacle ----------------
        pulse_in(); pulse_in();
        request();
        run_len(1, 0, n);
        step();
        pulse_in();
        check("obs.full", 32'(fl[1]), 1);
        check("obs.closing", 32'(g_dn[1]), 1);
        step();
        obstacle = 1'b1; step(); obstacle = 1'b0;
        check("obs.reopen", 32'(g_up[1]), 1);
        run_len(1, 0, n);
        obstacle = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (g_op[1] !== 1'b1) n++;
            step();
        end
        check("obs.held_open", n, 0);
        obstacle = 1'b0;
        run_len(1, 1, n);
        check("obs.release_len", n, 50);
        repeat (20) step();
`endif

        // ---------------- randomized ----------------
        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom_range(0, 599) == 0);
            entry_req = ($urandom_range(0, 3) == 0);
            car_in    = ($urandom_range(0, 7) == 0);
            car_out   = ($urandom_range(0, 7) == 0);
            obstacle  = OBS && ($urandom_range(0, 15) == 0);
            step();
        end
        reset = 1'b0; entry_req = 1'b0; car_in = 1'b0; car_out = 1'b0; obstacle = 1'b0;
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
